i2c_master_tx: RTL and testbench
================================

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 SHALL have parameter PRESCALE, default 250, meaning clk cycles per quarter SCL period (100 kHz at 100 MHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge on clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_dout  input  8  head byte of the upstream show-ahead TX FIFO, valid whenever fifo_empty=0.
REQ-005 SHALL have port fifo_empty  input  1  TX FIFO empty flag.
REQ-006 SHALL have port fifo_rd  output  1  one-cycle pop strobe to the TX FIFO.
REQ-007 SHALL have port sda_i  input  1  sampled SDA line level.
REQ-008 SHALL have port scl_oen  output  1  SCL output enable, active low (0 = drive low, 1 = release).
REQ-009 SHALL have port sda_oen  output  1  SDA output enable, active low.
REQ-010 SHALL have port busy  output  1  high while state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when STOP completes.
REQ-012 SHALL have port nack  output  1  sticky flag, set on a NACK.
REQ-013 SHALL have port nack_clr  input  1  single-cycle clear of nack.

Function
REQ-014 SHALL use a quarter tick: counter 0..PRESCALE-1, tick on terminal count, counter restarts at 0 on every state entry.
REQ-015 SHALL implement states IDLE, START, LOAD, DATA, ACK, STOP.
REQ-016 IDLE: lines released; SHALL go to START when fifo_empty=0 and nack=0.
REQ-017 START: q0 SCL/SDA released; q1 SDA low, SCL released; then LOAD.
REQ-018 LOAD: exactly one cycle, SCL low; fifo_rd=1, shift register <= fifo_dout, bit count <= 7; then DATA.
REQ-019 DATA: per bit, MSB first: q0,q1 SCL low with SDA = bit (0 drives low, 1 releases); q2,q3 SCL released; after bit 0, go to ACK.
REQ-020 ACK: SDA released; q0,q1 SCL low; q2,q3 SCL released; sda_i sampled on the q2 tick; 1 = NACK.
REQ-021 After ACK: NACK -> set nack, go to STOP; else fifo_empty=0 -> LOAD (no repeated START); else STOP.
REQ-022 STOP: q0 SCL low, SDA low; q1 SCL released, SDA low; q2 both released; at end of q2, done=1 for one cycle and go to IDLE.
REQ-023 fifo_rd SHALL pulse only in LOAD; never while fifo_empty=1; exactly once per byte sent.
REQ-024 After a NACK, bytes remaining in the FIFO SHALL stay untouched; no new transaction starts until nack is cleared.
REQ-025 nack_clr and a NACK in the same cycle: set wins.
REQ-026 Bytes written to the FIFO during a transfer SHALL be sent in the same transaction if present at the ACK decision.
REQ-027 No clock stretching and no arbitration; SCL is not read back.
REQ-028 scl_oen, sda_oen, fifo_rd and done SHALL be registered outputs.
REQ-029 One byte time SHALL be 36*PRESCALE cycles plus 1 LOAD cycle.

Reset
REQ-030 On rst: state IDLE; scl_oen=1, sda_oen=1, fifo_rd=0, done=0, nack=0, busy=0; counters cleared.
REQ-031 rst mid-transfer SHALL release both lines at the next edge; no STOP is generated and the partial byte is lost.

Structure
REQ-032 State encoding and the quarter-phase constants SHALL live in shared package i2c_pkg.
REQ-033 The quarter-tick prescaler SHALL be sub-module i2c_clk_div (ports clk, rst, restart, tick).

Verification
REQ-034 PRESCALE=4, FIFO holds 0xA5, sda_i=0 at ACK -> START, SDA bits 1,0,1,0,0,1,0,1, one fifo_rd, STOP, done pulse, nack=0.
REQ-035 PRESCALE=4, FIFO holds 0xA5,0x3C, ACK both -> single START, second byte 0,0,1,1,1,1,0,0, two fifo_rd pulses, one STOP.
REQ-036 FIFO holds 0x12,0x34, sda_i=1 at first ACK -> nack=1, one fifo_rd, STOP, 0x34 stays in FIFO, IDLE held until nack_clr, then new transaction sends 0x34.
REQ-037 rst asserted mid-DATA on bit 3 -> next edge scl_oen=1, sda_oen=1, busy=0; FIFO not popped again.
REQ-038 PRESCALE=4, byte written to FIFO during the first byte's bit 5 -> sent without STOP/START in between; byte-to-byte spacing 145 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C transmit-only master: FSM state encoding,
// the four quarter-phase identifiers of one SCL period, and the width of the
// quarter-tick prescaler counter.
// -----------------------------------------------------------------------------
package i2c_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DATA  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } i2c_state_t;

    // Quarter phases of one SCL period (q0,q1 = SCL low, q2,q3 = SCL high)
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Prescaler counter width; covers PRESCALE up to 65535
    localparam int CNT_W = 16;

endpackage

// File: rtl/i2c_clk_div.sv
// -----------------------------------------------------------------------------
// i2c_clk_div
// Quarter-SCL-period tick generator. A counter runs 0..PRESCALE-1 and tick is
// high for the single clk cycle in which the counter sits at its terminal
// count. restart forces the counter back to 0 on the next edge.
//
// Ports:
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset
//   restart in  1  return counter to 0 on the next edge
//   tick    out 1  registered, high while the counter is at PRESCALE-1
// -----------------------------------------------------------------------------
module i2c_clk_div
    import i2c_pkg::*;
#(
    parameter int PRESCALE = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Counter plus a registered terminal-count flag that tracks it exactly
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == TERM_CNT) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            tick_r <= ((cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == TERM_CNT);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/i2c_master_tx.sv
// -----------------------------------------------------------------------------
// i2c_master_tx
// Transmit-only I2C master. Drains a show-ahead TX FIFO: START, then every
// byte present (MSB first, one ACK slot each), then STOP. A NACK ends the
// transaction, sets a sticky flag and blocks new transactions until cleared.
// Every SCL period is split into four quarters of PRESCALE clk cycles.
//
// Ports:
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   fifo_dout  in  8  head byte of TX FIFO (valid while fifo_empty=0)
//   fifo_empty in  1  TX FIFO empty flag
//   fifo_rd    out 1  one-cycle pop strobe (registered)
//   sda_i      in  1  sampled SDA line level
//   scl_oen    out 1  SCL enable, 0 = drive low, 1 = release (registered)
//   sda_oen    out 1  SDA enable, 0 = drive low, 1 = release (registered)
//   busy       out 1  state is not IDLE
//   done       out 1  one-cycle pulse when STOP completes (registered)
//   nack       out 1  sticky NACK flag
//   nack_clr   in  1  single-cycle clear of nack
// -----------------------------------------------------------------------------
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int PRESCALE = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       sda_i,
    output logic       scl_oen,
    output logic       sda_oen,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       nack_clr
);

    i2c_state_t state_r;
    logic [1:0] q_r;
    logic [7:0] sh_r;
    logic [2:0] bit_r;
    logic       ack_r;
    logic       nack_r;
    logic       scl_oen_r;
    logic       sda_oen_r;
    logic       fifo_rd_r;
    logic       done_r;
    logic       tick_s;
    logic       restart_s;

    // Every state except IDLE and LOAD is left on a tick, where the counter
    // wraps to 0 by itself; holding it at 0 in IDLE and LOAD therefore makes
    // every state start with a fresh quarter.
    assign restart_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);

    i2c_clk_div #(
        .PRESCALE (PRESCALE)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Transmit FSM; line levels are registered for the phase being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            q_r       <= Q0;
            sh_r      <= 8'h00;
            bit_r     <= 3'd0;
            ack_r     <= 1'b0;
            nack_r    <= 1'b0;
            scl_oen_r <= 1'b1;
            sda_oen_r <= 1'b1;
            fifo_rd_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            fifo_rd_r <= 1'b0;
            done_r    <= 1'b0;
            // A NACK set later in this block overrides the clear
            if (nack_clr) begin
                nack_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    q_r       <= Q0;
                    scl_oen_r <= 1'b1;
                    sda_oen_r <= 1'b1;
                    if (!fifo_empty && !nack_r) begin
                        state_r <= ST_START;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_START: begin
                    if (tick_s) begin
                        if (q_r == Q0) begin
                            q_r       <= Q1;
                            sda_oen_r <= 1'b0;   // START: SDA falls, SCL high
                        end else begin
                            state_r   <= ST_LOAD;
                            scl_oen_r <= 1'b0;
                            fifo_rd_r <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    sh_r      <= fifo_dout;
                    bit_r     <= 3'd7;
                    q_r       <= Q0;
                    state_r   <= ST_DATA;
                    scl_oen_r <= 1'b0;
                    sda_oen_r <= fifo_dout[7];
                end

                ST_DATA: begin
                    if (tick_s) begin
                        case (q_r)
                            Q0: q_r <= Q1;
                            Q1: begin
                                q_r       <= Q2;
                                scl_oen_r <= 1'b1;
                            end
                            Q2: q_r <= Q3;
                            default: begin
                                q_r       <= Q0;
                                scl_oen_r <= 1'b0;
                                if (bit_r == 3'd0) begin
                                    state_r   <= ST_ACK;
                                    sda_oen_r <= 1'b1;
                                end else begin
                                    bit_r     <= bit_r - 3'd1;
                                    sh_r      <= {sh_r[6:0], 1'b0};
                                    sda_oen_r <= sh_r[6];
                                end
                            end
                        endcase
                    end
                end

                ST_ACK: begin
                    if (tick_s) begin
                        case (q_r)
                            Q0: q_r <= Q1;
                            Q1: begin
                                q_r       <= Q2;
                                scl_oen_r <= 1'b1;
                            end
                            Q2: begin
                                q_r   <= Q3;
                                ack_r <= sda_i;   // 1 = NACK
                            end
                            default: begin
                                q_r       <= Q0;
                                scl_oen_r <= 1'b0;
                                if (ack_r) begin
                                    nack_r    <= 1'b1;
                                    state_r   <= ST_STOP;
                                    sda_oen_r <= 1'b0;
                                end else if (!fifo_empty) begin
                                    // Next byte joins this transaction
                                    state_r   <= ST_LOAD;
                                    fifo_rd_r <= 1'b1;
                                    sda_oen_r <= 1'b1;
                                end else begin
                                    state_r   <= ST_STOP;
                                    sda_oen_r <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                ST_STOP: begin
                    if (tick_s) begin
                        case (q_r)
                            Q0: begin
                                q_r       <= Q1;
                                scl_oen_r <= 1'b1;
                            end
                            Q1: begin
                                q_r       <= Q2;
                                sda_oen_r <= 1'b1;   // STOP: SDA rises, SCL high
                            end
                            default: begin
                                q_r     <= Q0;
                                state_r <= ST_IDLE;
                                done_r  <= 1'b1;
                            end
                        endcase
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    q_r       <= Q0;
                    scl_oen_r <= 1'b1;
                    sda_oen_r <= 1'b1;
                end
            endcase
        end
    end

    assign scl_oen = scl_oen_r;
    assign sda_oen = sda_oen_r;
    assign fifo_rd = fifo_rd_r;
    assign done    = done_r;
    assign nack    = nack_r;
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_i2c_master_tx.sv
// -----------------------------------------------------------------------------
// tb_i2c_master_tx
// Directed bench for i2c_master_tx with PRESCALE=4. A show-ahead FIFO model
// feeds the DUT, a bus monitor/slave decodes START, STOP, data bits and ACK
// slots and answers ACK or NACK. Expected bytes are queued when written and
// compared with monitored bytes once each transaction finishes.
// -----------------------------------------------------------------------------
module tb_i2c_master_tx;

    localparam int P = 4;

    logic       clk;
    logic       rst;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd;
    logic       sda_i;
    logic       scl_oen;
    logic       sda_oen;
    logic       busy;
    logic       done;
    logic       nack;
    logic       nack_clr;

    i2c_master_tx #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .sda_i      (sda_i),
        .scl_oen    (scl_oen),
        .sda_oen    (sda_oen),
        .busy       (busy),
        .done       (done),
        .nack       (nack),
        .nack_clr   (nack_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO model ----------------
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] mem [0:15];
    logic [4:0] wptr = 5'd0;
    logic [4:0] rptr = 5'd0;
    int         cyc = 0;
    int         rd_cnt = 0;
    int         underflow = 0;
    int         rd_time [0:63];

    assign fifo_empty = (wptr == rptr);
    assign fifo_dout  = mem[rptr[3:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            mem[wptr[3:0]] <= wr_data;
            wptr <= wptr + 5'd1;
        end
        if (fifo_rd) begin
            if (wptr == rptr) underflow <= underflow + 1;
            else rptr <= rptr + 5'd1;
            rd_time[rd_cnt] <= cyc;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // ---------------- bus monitor / slave ----------------
    logic       nack_req;
    logic       sda_drv = 1'b1;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] mon_sh = 8'h00;
    int         bitcnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         done_cnt = 0;
    int         obs_cnt = 0;
    logic [7:0] obs_byte [0:63];
    logic       obs_ack  [0:63];
    logic       mon_scl;
    logic       mon_sda;

    assign mon_scl = scl_oen;
    assign mon_sda = sda_oen & sda_drv;
    assign sda_i   = mon_sda;

    always @(negedge clk) begin
        prev_scl <= mon_scl;
        prev_sda <= mon_sda;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            bitcnt  <= 0;
            sda_drv <= 1'b1;
        end else if (mon_scl && prev_scl && prev_sda && !mon_sda) begin
            start_cnt <= start_cnt + 1;
            bitcnt    <= 0;
        end else if (mon_scl && prev_scl && !prev_sda && mon_sda) begin
            stop_cnt <= stop_cnt + 1;
            bitcnt   <= 0;
        end else if (mon_scl && !prev_scl) begin
            if (bitcnt < 8) begin
                mon_sh <= {mon_sh[6:0], mon_sda};
                bitcnt <= bitcnt + 1;
            end else begin
                obs_byte[obs_cnt] <= mon_sh;
                obs_ack[obs_cnt]  <= mon_sda;
                obs_cnt <= obs_cnt + 1;
                bitcnt  <= 0;
            end
        end else if (!mon_scl && prev_scl) begin
            sda_drv <= (bitcnt == 8) ? nack_req : 1'b1;
        end
    end

    // ---------------- checking ----------------
    int         errors = 0;
    int         checks = 0;
    int         rd_idx = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_bits(input int k, input string tag);
        int n;
        n = 0;
        while (bitcnt != k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, bitcnt, k);
    endtask

    task automatic wait_scl_low(input string tag);
        int n;
        n = 0;
        while (scl_oen !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, scl_oen}, 32'd0);
    endtask

    task automatic sb_drain(input string tag);
        logic [8:0] e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_avail"}, {31'd0, (obs_cnt > rd_idx)}, 32'd1);
            if (rd_idx < obs_cnt) begin
                check(tag, {23'd0, obs_ack[rd_idx], obs_byte[rd_idx]}, {23'd0, e});
                rd_idx++;
            end
        end
    endtask

    int st0, sp0, rd0, dn0;

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        nack_clr = 1'b0;
        nack_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", {31'd0, scl_oen}, 32'd1);
        check("rst_sda", {31'd0, sda_oen}, 32'd1);
        check("rst_rd",  {31'd0, fifo_rd}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_nack", {31'd0, nack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // --- single byte 0xA5, ACKed ---
        st0 = start_cnt; sp0 = stop_cnt; rd0 = rd_cnt; dn0 = done_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        push(8'hA5);
        repeat (3) @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done");
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        sb_drain("t1_byte");
        check("t1_starts", start_cnt - st0, 1);
        check("t1_stops", stop_cnt - sp0, 1);
        check("t1_rd", rd_cnt - rd0, 1);
        check("t1_dones", done_cnt - dn0, 1);
        check("t1_nack", {31'd0, nack}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // --- two bytes 0xA5, 0x3C in one transaction ---
        st0 = start_cnt; sp0 = stop_cnt; rd0 = rd_cnt;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        push(8'hA5);
        push(8'h3C);
        wait_done("t2_done");
        repeat (2) @(negedge clk);
        sb_drain("t2_byte");
        check("t2_starts", start_cnt - st0, 1);
        check("t2_stops", stop_cnt - sp0, 1);
        check("t2_rd", rd_cnt - rd0, 2);
        check("t2_spacing", rd_time[rd0 + 1] - rd_time[rd0], 36 * P + 1);

        // --- NACK on 0x12; 0x34 stays queued until nack_clr ---
        st0 = start_cnt; sp0 = stop_cnt; rd0 = rd_cnt;
        nack_req = 1'b1;
        exp_q.push_back({1'b1, 8'h12});
        push(8'h12);
        push(8'h34);
        wait_done("t3_done");
        check("t3_nack", {31'd0, nack}, 32'd1);
        repeat (2) @(negedge clk);
        sb_drain("t3_byte");
        check("t3_rd", rd_cnt - rd0, 1);
        check("t3_stops", stop_cnt - sp0, 1);
        check("t3_fifo_kept", {31'd0, fifo_empty}, 32'd0);
        check("t3_fifo_head", {24'd0, fifo_dout}, 32'h34);
        repeat (100) @(negedge clk);
        check("t3_hold_busy", {31'd0, busy}, 32'd0);
        check("t3_hold_starts", start_cnt - st0, 1);
        check("t3_hold_rd", rd_cnt - rd0, 1);
        nack_req = 1'b0;
        nack_clr = 1'b1;
        @(negedge clk);
        nack_clr = 1'b0;
        check("t3_nack_clr", {31'd0, nack}, 32'd0);
        exp_q.push_back({1'b0, 8'h34});
        wait_done("t3b_done");
        repeat (2) @(negedge clk);
        sb_drain("t3b_byte");
        check("t3b_rd", rd_cnt - rd0, 2);
        check("t3b_nack", {31'd0, nack}, 32'd0);

        // --- reset in the middle of bit 3 ---
        rd0 = rd_cnt;
        push(8'h5A);
        wait_bits(4, "t4_bit4");
        wait_scl_low("t4_bit3");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t4_scl", {31'd0, scl_oen}, 32'd1);
        check("t4_sda", {31'd0, sda_oen}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t4_rd", rd_cnt - rd0, 1);
        check("t4_idle", {31'd0, busy}, 32'd0);

        // --- second byte written during the first byte's bit 5 ---
        st0 = start_cnt; sp0 = stop_cnt; rd0 = rd_cnt;
        exp_q.push_back({1'b0, 8'h81});
        exp_q.push_back({1'b0, 8'h7E});
        push(8'h81);
        wait_bits(2, "t5_bit6");
        wait_scl_low("t5_bit5");
        push(8'h7E);
        wait_done("t5_done");
        repeat (2) @(negedge clk);
        sb_drain("t5_byte");
        check("t5_starts", start_cnt - st0, 1);
        check("t5_stops", stop_cnt - sp0, 1);
        check("t5_rd", rd_cnt - rd0, 2);
        check("t5_spacing", rd_time[rd0 + 1] - rd_time[rd0], 145);

        check("no_extra_bytes", obs_cnt, rd_idx);
        check("no_underflow", underflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
